receipt_display_updater: RTL and testbench
==========================================

Name: receipt_display_updater

Overview:
- Command-driven owner of the text controller's content registers: `product_IDS`, `numbers` and `total_price`.
- Accepts ADD, REMOVE_LAST and CLEAR sale commands from the terminal logic.
- Keeps a shadow receipt list and a BCD running total, using a digit-serial BCD add/subtract datapath.
- Copies the shadow into the display registers only during vertical blank, so the text never tears mid-frame.

Parameters:
- SLOTS, 12, number of receipt lines.
- ID_W, 4, product ID width in bits.
- DIGITS, 5, BCD digits per price and per total.
- V_ACTIVE, 600, first blank line; V_counter >= V_ACTIVE means vertical blank.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- V_counter  in  10  vertical line counter from the VGA timing block.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  01=ADD, 10=REMOVE_LAST, 11=CLEAR, 00=NOP (accepted, no effect).
- cmd_id  in  4  product ID for ADD.
- cmd_price  in  20  BCD unit price for ADD.
- product_IDS  out  48  display IDs; slot i occupies [47-4i -: 4].
- numbers  out  240  display prices; slot i occupies [239-20i -: 20].
- total_price  out  20  display BCD total.
- item_count  out  4  live shadow count, 0..SLOTS.
- price_ovf  out  1  sticky; total saturated.
- cmd_err  out  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset: clock is CLK; reset is synchronous and active-high on RST. On RST:
  - all display and shadow registers are 0;
  - item_count=0, price_ovf=0, cmd_err=0;
  - state=IDLE, dirty=0.
  - RST overrides everything, including mid-CALC; cmd_ready is high on the first cycle after RST falls.
- Handshake: a command is accepted when cmd_valid and cmd_ready are both high.
- FSM states: IDLE, CALC.
- ADD accepted with item_count < SLOTS:
  - Accept cycle: shadow slot[item_count] <= {cmd_id, cmd_price}; item_count++; operand <= cmd_price; op=add; dirty=1; go to CALC.
- REMOVE_LAST accepted with item_count > 0:
  - Accept cycle: operand <= shadow price of the last slot; that slot is cleared to 0; item_count--; op=sub; dirty=1; go to CALC.
- CLEAR accepted:
  - Same cycle: all shadow slots, shadow total, item_count and price_ovf are cleared; dirty=1; stay in IDLE.
- Rejected commands: ADD when full or REMOVE_LAST when empty.
  - The command is still accepted (handshake completes).
  - cmd_err pulses on the next cycle; no state change.
- CALC timing:
  - Exactly DIGITS cycles, one BCD digit per cycle, LSB digit first.
  - Add: digit = a+b+carry; if the sum > 9, subtract 10 and set carry.
  - Sub: digit = a-b-borrow; if negative, add 10 and set borrow.
  - The result digit is written into the shadow total each cycle.
  - After the last digit, return to IDLE. The accept cycle is T; CALC spans T+1..T+5; cmd_ready is high again at T+6.
- Carry out of the top digit on add: shadow total <= 99999, price_ovf <= 1.
- Final borrow on sub: shadow total <= 0. Reachable only after saturation.
- Commit to display:
  - Condition: any cycle where state==IDLE, dirty==1 and V_counter >= V_ACTIVE.
  - Action: display registers <= shadow; dirty <= 0.
  - A command accepted in the same cycle is not lost: the commit takes the pre-command shadow and dirty stays 1.
  - The display registers change only on commit cycles.
- Blocked commit: no commit while in CALC. If blank ends during CALC, the commit waits for the next frame's blank.
- Empty slots display ID 0 and price 00000.

Decomposition:
- Shared package holds:
  - op codes;
  - SLOTS, ID_W, DIGITS, V_ACTIVE;
  - slot bit-offset functions for ID and price;
  - the FSM state encoding.
- One natural sub-module: `bcd_digit_addsub`, combinational 4-bit digit add/subtract with carry/borrow in and out, instantiated once.

Test Plan:
- Reset, then ADD id=5 price=0x00123 while V_counter=100.
  - cmd_ready is low for 5 cycles.
  - Shadow total is 0x00123 and item_count=1.
  - Display stays 0 until V_counter=600, then product_IDS[47:44]=5, numbers[239:220]=0x00123, total_price=0x00123.
- ADD 0x00999 then ADD 0x00002 → total 0x01001, with carries propagating across 3 digits. REMOVE_LAST → total 0x00999 and slot 1 cleared.
- Twelve ADDs of 0x00001 → item_count=12, total 0x00012. A 13th ADD → cmd_err pulse, and count, slots and total unchanged.
- REMOVE_LAST on empty → cmd_err pulse. ADD 0x99999 twice → total 0x99999 and price_ovf=1. CLEAR → all zero and price_ovf=0 on the next commit.
- ADD accepted with V_counter=599 and the 5-cycle CALC straddling line 600 → commit occurs on the first IDLE cycle with V_counter >= 600. Also: ADD accepted at V_counter=799 with blank ending mid-CALC → commit waits for the next frame's line 600.
- Assert RST during CALC → all outputs 0 on the next cycle, and cmd_ready=1 after release.

Source files
------------

// File: rtl/receipt_display_updater_pkg.sv
// Shared constants, types and slot-offset helpers for the receipt display updater.
// No logic of its own; no latency or backpressure.
package receipt_display_updater_pkg;

    localparam int SLOTS    = 12;
    localparam int ID_W     = 4;
    localparam int DIGITS   = 5;
    localparam int V_ACTIVE = 600;

    localparam int PRICE_W  = 4 * DIGITS;
    localparam int CNT_W    = $clog2(SLOTS + 1);
    localparam int IDX_W    = $clog2(DIGITS);
    localparam int VCNT_W   = 10;

    localparam logic [CNT_W-1:0]   SLOTS_CNT  = CNT_W'(SLOTS);
    localparam logic [IDX_W-1:0]   DIGIT_LAST = IDX_W'(DIGITS - 1);
    localparam logic [VCNT_W-1:0]  V_BLANK    = VCNT_W'(V_ACTIVE);
    localparam logic [PRICE_W-1:0] PRICE_MAX  = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_ADD    = 2'b01,
        OP_REMOVE = 2'b10,
        OP_CLEAR  = 2'b11
    } cmd_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_t;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [PRICE_W-1:0] price;
    } slot_t;

    // Slot 0 sits in the most significant field of each display bus.
    function automatic int id_lsb(input int slot);
        return (SLOTS - 1 - slot) * ID_W;
    endfunction

    function automatic int price_lsb(input int slot);
        return (SLOTS - 1 - slot) * PRICE_W;
    endfunction

endpackage

// File: rtl/receipt_display_updater_bcd_digit_addsub.sv
// Single BCD digit adder/subtractor with carry/borrow chaining.
// Purely combinational, zero latency; no backpressure.
module bcd_digit_addsub (
    input  logic       sub,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] d,
    output logic       cout
);

    logic [4:0] sum_raw;
    logic [4:0] sum_adj;
    logic [4:0] dif_raw;
    logic [3:0] dif_adj;

    always_comb begin
        sum_raw = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        sum_adj = sum_raw - 5'd10;
        // Two's-complement difference lies in -10..9, so bit 4 is the sign.
        dif_raw = {1'b0, a} - {1'b0, b} - {4'b0, cin};
        dif_adj = dif_raw[3:0] + 4'd10;
        d       = 4'd0;
        cout    = 1'b0;
        if (sub) begin
            cout = dif_raw[4];
            d    = dif_raw[4] ? dif_adj : dif_raw[3:0];
        end else begin
            cout = (sum_raw > 5'd9);
            d    = cout ? sum_adj[3:0] : sum_raw[3:0];
        end
    end

endmodule

// File: rtl/receipt_display_updater.sv
// Command-driven receipt shadow with digit-serial BCD total, copied to display in vblank.
// ADD/REMOVE take 1 accept + DIGITS calc cycles; cmd_ready drops while the total is updating.
module receipt_display_updater
    import receipt_display_updater_pkg::*;
(
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [VCNT_W-1:0]         V_counter,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [ID_W-1:0]           cmd_id,
    input  logic [PRICE_W-1:0]        cmd_price,
    output logic [SLOTS*ID_W-1:0]     product_IDS,
    output logic [SLOTS*PRICE_W-1:0]  numbers,
    output logic [PRICE_W-1:0]        total_price,
    output logic [CNT_W-1:0]          item_count,
    output logic                      price_ovf,
    output logic                      cmd_err
);

    state_t               state, state_nxt;
    slot_t                shadow [SLOTS];
    logic [PRICE_W-1:0]   shadow_total;
    logic [PRICE_W-1:0]   operand;
    logic                 op_sub;
    logic                 carry;
    logic [IDX_W-1:0]     digit_idx;
    logic                 dirty;

    cmd_op_t              op;
    logic                 accept;
    logic                 is_full;
    logic                 is_empty;
    logic                 start_calc;
    logic                 commit;
    logic                 last_digit;
    logic [CNT_W-1:0]     last_idx;

    logic [3:0]           dig_a, dig_b, dig_d;
    logic                 dig_cout;

    logic [SLOTS*ID_W-1:0]    shadow_ids;
    logic [SLOTS*PRICE_W-1:0] shadow_prices;

    assign op         = cmd_op_t'(cmd_op);
    assign is_full    = (item_count >= SLOTS_CNT);
    assign is_empty   = (item_count == '0);
    assign last_idx   = item_count - CNT_W'(1);
    assign accept     = cmd_valid && cmd_ready;
    assign start_calc = ((op == OP_ADD) && !is_full) || ((op == OP_REMOVE) && !is_empty);
    assign last_digit = (digit_idx == DIGIT_LAST);
    assign commit     = (state == ST_IDLE) && dirty && (V_counter >= V_BLANK);

    assign dig_a = shadow_total[{digit_idx, 2'b00} +: 4];
    assign dig_b = operand[{digit_idx, 2'b00} +: 4];

    bcd_digit_addsub u_digit (
        .sub  (op_sub),
        .a    (dig_a),
        .b    (dig_b),
        .cin  (carry),
        .d    (dig_d),
        .cout (dig_cout)
    );

    always_comb begin
        shadow_ids    = '0;
        shadow_prices = '0;
        for (int i = 0; i < SLOTS; i++) begin
            shadow_ids[id_lsb(i) +: ID_W]          = shadow[i].id;
            shadow_prices[price_lsb(i) +: PRICE_W] = shadow[i].price;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && start_calc) state_nxt = ST_CALC;
            end
            ST_CALC: begin
                if (last_digit) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SLOTS; i++) shadow[i] <= '0;
            shadow_total <= '0;
            operand      <= '0;
            op_sub       <= 1'b0;
            carry        <= 1'b0;
            digit_idx    <= '0;
            dirty        <= 1'b0;
            item_count   <= '0;
            price_ovf    <= 1'b0;
            cmd_err      <= 1'b0;
            product_IDS  <= '0;
            numbers      <= '0;
            total_price  <= '0;
        end else begin
            cmd_err <= 1'b0;

            // Commit sees pre-command shadow; a same-cycle command re-arms dirty below.
            if (commit) begin
                product_IDS <= shadow_ids;
                numbers     <= shadow_prices;
                total_price <= shadow_total;
                dirty       <= 1'b0;
            end

            if (state == ST_CALC) begin
                shadow_total[{digit_idx, 2'b00} +: 4] <= dig_d;
                carry     <= dig_cout;
                digit_idx <= digit_idx + IDX_W'(1);
                if (last_digit) begin
                    digit_idx <= '0;
                    if (dig_cout) begin
                        shadow_total <= op_sub ? '0 : PRICE_MAX;
                        if (!op_sub) price_ovf <= 1'b1;
                    end
                end
            end else if (accept) begin
                case (op)
                    OP_ADD: begin
                        if (is_full) begin
                            cmd_err <= 1'b1;
                        end else begin
                            shadow[item_count] <= '{id: cmd_id, price: cmd_price};
                            item_count <= item_count + CNT_W'(1);
                            operand    <= cmd_price;
                            op_sub     <= 1'b0;
                            carry      <= 1'b0;
                            digit_idx  <= '0;
                            dirty      <= 1'b1;
                        end
                    end
                    OP_REMOVE: begin
                        if (is_empty) begin
                            cmd_err <= 1'b1;
                        end else begin
                            operand          <= shadow[last_idx].price;
                            shadow[last_idx] <= '0;
                            item_count       <= last_idx;
                            op_sub           <= 1'b1;
                            carry            <= 1'b0;
                            digit_idx        <= '0;
                            dirty            <= 1'b1;
                        end
                    end
                    OP_CLEAR: begin
                        for (int i = 0; i < SLOTS; i++) shadow[i] <= '0;
                        shadow_total <= '0;
                        item_count   <= '0;
                        price_ovf    <= 1'b0;
                        dirty        <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_receipt_display_updater.sv
// Directed self-checking bench for receipt_display_updater.
module tb_receipt_display_updater;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [9:0]    V_counter = 10'd100;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [3:0]    cmd_id = 4'd0;
    logic [19:0]   cmd_price = 20'h0;
    logic [47:0]   product_IDS;
    logic [239:0]  numbers;
    logic [19:0]   total_price;
    logic [3:0]    item_count;
    logic          price_ovf;
    logic          cmd_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [239:0] exp_num;

    receipt_display_updater dut (
        .CLK         (CLK),
        .RST         (RST),
        .V_counter   (V_counter),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_id      (cmd_id),
        .cmd_price   (cmd_price),
        .product_IDS (product_IDS),
        .numbers     (numbers),
        .total_price (total_price),
        .item_count  (item_count),
        .price_ovf   (price_ovf),
        .cmd_err     (cmd_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        if (cmd_ready !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: cmd_ready observed %b required 1 within 20 cycles", cmd_ready);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] id, input logic [19:0] price);
        wait_idle();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_id    = id;
        cmd_price = price;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
    endtask

    task automatic commit_now();
        wait_idle();
        V_counter = 10'd600;
        tick();
        V_counter = 10'd100;
    endtask

    initial begin
        // Reset
        tick(); tick();
        chk("rst_ids",   256'(product_IDS), 256'(48'h0));
        chk("rst_num",   256'(numbers),     256'(240'h0));
        chk("rst_total", 256'(total_price), 256'(20'h0));
        chk("rst_cnt",   256'(item_count),  256'(4'd0));
        chk("rst_ovf",   256'(price_ovf),   256'(1'b0));
        chk("rst_err",   256'(cmd_err),     256'(1'b0));
        RST = 1'b0;
        tick();
        chk("rst_ready", 256'(cmd_ready), 256'(1'b1));

        // First ADD, busy window and vblank commit
        send(2'b01, 4'd5, 20'h00123);
        for (int i = 0; i < 5; i++) begin
            chk("busy_ready", 256'(cmd_ready), 256'(1'b0));
            tick();
        end
        chk("ready_back", 256'(cmd_ready),  256'(1'b1));
        chk("add1_cnt",   256'(item_count), 256'(4'd1));
        tick(); tick();
        chk("no_commit_active", 256'(total_price), 256'(20'h0));
        commit_now();
        chk("c1_id",    256'(product_IDS[47:44]), 256'(4'd5));
        chk("c1_price", 256'(numbers[239:220]),   256'(20'h00123));
        chk("c1_total", 256'(total_price),        256'(20'h00123));
        chk("c1_ids",   256'(product_IDS),        256'(48'h500000000000));

        // Carry ripple and REMOVE_LAST
        send(2'b11, 4'd0, 20'h0);
        send(2'b01, 4'd1, 20'h00999);
        send(2'b01, 4'd2, 20'h00002);
        commit_now();
        exp_num = '0;
        exp_num[239 -: 20] = 20'h00999;
        exp_num[219 -: 20] = 20'h00002;
        chk("carry_total", 256'(total_price), 256'(20'h01001));
        chk("carry_num",   256'(numbers),     256'(exp_num));
        chk("carry_ids",   256'(product_IDS), 256'(48'h120000000000));
        send(2'b10, 4'd0, 20'h0);
        commit_now();
        exp_num[219 -: 20] = 20'h0;
        chk("rm_total", 256'(total_price), 256'(20'h00999));
        chk("rm_num",   256'(numbers),     256'(exp_num));
        chk("rm_ids",   256'(product_IDS), 256'(48'h100000000000));
        chk("rm_cnt",   256'(item_count),  256'(4'd1));

        // Fill to capacity, then overfill
        send(2'b11, 4'd0, 20'h0);
        for (int i = 0; i < 12; i++) send(2'b01, 4'(i + 1), 20'h00001);
        commit_now();
        chk("full_cnt",   256'(item_count),  256'(4'd12));
        chk("full_total", 256'(total_price), 256'(20'h00012));
        chk("full_ids",   256'(product_IDS), 256'(48'h123456789ABC));
        chk("full_num",   256'(numbers),     256'({12{20'h00001}}));
        send(2'b01, 4'd7, 20'h00500);
        chk("ovr_err",   256'(cmd_err),   256'(1'b1));
        chk("ovr_ready", 256'(cmd_ready), 256'(1'b1));
        tick();
        chk("ovr_err_pulse", 256'(cmd_err),    256'(1'b0));
        chk("ovr_cnt",       256'(item_count), 256'(4'd12));
        send(2'b10, 4'd0, 20'h0);
        commit_now();
        exp_num = {12{20'h00001}};
        exp_num[19:0] = 20'h0;
        chk("ovr_rm_total", 256'(total_price), 256'(20'h00011));
        chk("ovr_rm_num",   256'(numbers),     256'(exp_num));
        chk("ovr_rm_ids",   256'(product_IDS), 256'(48'h123456789AB0));

        // Empty remove, saturation, borrow clamp, clear
        send(2'b11, 4'd0, 20'h0);
        commit_now();
        chk("clr_total", 256'(total_price), 256'(20'h0));
        send(2'b10, 4'd0, 20'h0);
        chk("empty_err", 256'(cmd_err),    256'(1'b1));
        chk("empty_cnt", 256'(item_count), 256'(4'd0));
        send(2'b01, 4'd9, 20'h99999);
        wait_idle();
        chk("sat1_ovf", 256'(price_ovf), 256'(1'b0));
        send(2'b01, 4'd9, 20'h99999);
        commit_now();
        chk("sat2_ovf",   256'(price_ovf),   256'(1'b1));
        chk("sat2_total", 256'(total_price), 256'(20'h99999));
        send(2'b10, 4'd0, 20'h0);
        commit_now();
        chk("sub_zero", 256'(total_price), 256'(20'h0));
        send(2'b10, 4'd0, 20'h0);
        commit_now();
        chk("borrow_clamp", 256'(total_price), 256'(20'h0));
        chk("ovf_sticky",   256'(price_ovf),   256'(1'b1));
        send(2'b01, 4'd6, 20'h00042);
        send(2'b11, 4'd0, 20'h0);
        chk("clr_ovf", 256'(price_ovf), 256'(1'b0));
        commit_now();
        chk("clr2_total", 256'(total_price), 256'(20'h0));
        chk("clr2_ids",   256'(product_IDS), 256'(48'h0));
        chk("clr2_num",   256'(numbers),     256'(240'h0));
        chk("clr2_cnt",   256'(item_count),  256'(4'd0));

        // Calc straddling line 600
        V_counter = 10'd599;
        send(2'b01, 4'd3, 20'h00050);
        V_counter = 10'd600;
        for (int i = 0; i < 5; i++) begin
            chk("straddle_hold", 256'(total_price), 256'(20'h0));
            tick();
        end
        chk("straddle_idle_pre", 256'(total_price), 256'(20'h0));
        tick();
        chk("straddle_commit", 256'(total_price), 256'(20'h00050));
        chk("straddle_id",     256'(product_IDS), 256'(48'h300000000000));

        // Blank ends mid-calc; commit waits for next frame
        V_counter = 10'd799;
        send(2'b01, 4'd4, 20'h00007);
        V_counter = 10'd0;
        for (int i = 0; i < 10; i++) tick();
        chk("wrap_hold", 256'(total_price), 256'(20'h00050));
        V_counter = 10'd600;
        tick();
        V_counter = 10'd100;
        chk("wrap_commit", 256'(total_price), 256'(20'h00057));
        chk("wrap_ids",    256'(product_IDS), 256'(48'h340000000000));

        // Reset during calc
        send(2'b01, 4'd1, 20'h00005);
        tick();
        RST = 1'b1;
        tick();
        chk("mid_rst_ids",   256'(product_IDS), 256'(48'h0));
        chk("mid_rst_num",   256'(numbers),     256'(240'h0));
        chk("mid_rst_total", 256'(total_price), 256'(20'h0));
        chk("mid_rst_cnt",   256'(item_count),  256'(4'd0));
        chk("mid_rst_ovf",   256'(price_ovf),   256'(1'b0));
        RST = 1'b0;
        tick();
        chk("mid_rst_ready", 256'(cmd_ready), 256'(1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
